seg14_frame_driver: RTL and testbench



---
 rtl/seg14_frame_driver_if.sv | 19 +
 rtl/seg14_frame_driver.sv | 104 ++++++++++
 tb/tb_seg14_frame_driver.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/seg14_frame_driver_if.sv
// Pattern handshake between the sequencer and the 14-segment output stage.
// The sequencer is the master and the frame driver is the slave.
interface seg14_frame_driver_if;
   logic [13:0] pat_in;
   logic        pat_valid;
   logic        pat_ready;

   modport master (
      output pat_in,
      output pat_valid,
      input  pat_ready
   );

   modport slave (
      input  pat_in,
      input  pat_valid,
      output pat_ready
   );
endinterface

// File: rtl/seg14_frame_driver.sv
// 14-segment output stage: double-buffered pattern swapped on PWM frame
// boundaries, with brightness PWM, blink, lamp test and pin polarity.
module seg14_frame_driver #(
   parameter int unsigned PWM_BITS   = 4,
   parameter int unsigned BLINK_BITS = 6,
   parameter bit          ACTIVE_LOW = 1'b1
) (
   input  logic                clk,
   input  logic                rst_n,
   seg14_frame_driver_if.slave pat,
   input  logic [PWM_BITS-1:0] brightness,
   input  logic                blink_en,
   input  logic                lamp_test,
   output logic [13:0]         disp,
   output logic                frame_tick
);

   localparam logic [13:0] ALL_ON  = 14'h3FFF;
   localparam logic [13:0] PIN_OFF = ACTIVE_LOW ? 14'h3FFF : 14'h0000;

   logic [PWM_BITS-1:0]   r_pwm_ctr;
   logic [13:0]           r_pend;
   logic                  r_pend_full;
   logic [13:0]           r_act;
   logic [PWM_BITS-1:0]   r_br_q;
   logic [BLINK_BITS-1:0] r_blink_ctr;
   logic [13:0]           r_disp;
   logic                  r_frame_tick;

   logic                  w_boundary;
   logic                  w_accept;
   logic                  w_swap;
   logic                  w_on;
   logic                  w_blank;
   logic [13:0]           w_seg;
   logic [13:0]           w_pin;

   assign w_boundary = (r_pwm_ctr == {PWM_BITS{1'b1}});
   assign w_accept   = pat.pat_valid && !r_pend_full;
   // Swap needs a full buffer, accept needs an empty one: never both.
   assign w_swap     = w_boundary && r_pend_full;

   assign pat.pat_ready = !r_pend_full;

   always_comb begin
      w_on    = (r_pwm_ctr < r_br_q);
      w_blank = blink_en && r_blink_ctr[BLINK_BITS-1];
      w_seg   = 14'h0000;
      if (lamp_test) begin
         w_seg = ALL_ON;
      end else if (w_on && !w_blank) begin
         w_seg = r_act;
      end
      w_pin = ACTIVE_LOW ? ~w_seg : w_seg;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pwm_ctr <= '0;
      end else begin
         r_pwm_ctr <= r_pwm_ctr + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pend      <= '0;
         r_pend_full <= 1'b0;
         r_act       <= '0;
      end else begin
         if (w_accept) begin
            r_pend      <= pat.pat_in;
            r_pend_full <= 1'b1;
         end else if (w_swap) begin
            r_act       <= r_pend;
            r_pend_full <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_br_q      <= '0;
         r_blink_ctr <= '0;
      end else if (w_boundary) begin
         r_br_q      <= brightness;
         r_blink_ctr <= r_blink_ctr + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_disp       <= PIN_OFF;
         r_frame_tick <= 1'b0;
      end else begin
         r_disp       <= w_pin;
         r_frame_tick <= w_boundary;
      end
   end

   assign disp       = r_disp;
   assign frame_tick = r_frame_tick;

endmodule

// File: tb/tb_seg14_frame_driver.sv
// Bench for seg14_frame_driver: randomized pattern traffic against a
// frame-level reference model, checked through a scoreboard queue.
module tb_seg14_frame_driver;

   localparam int FRAME = 16;
   localparam int BLINK_FRAMES = 4;

   typedef struct {
      logic [13:0] disp;
      logic        ready;
      logic        tick;
   } exp_t;

   logic       clk;
   logic       rst_n;
   logic [3:0] brightness;
   logic       blink_en;
   logic       lamp_test;
   logic [13:0] disp;
   logic       frame_tick;

   seg14_frame_driver_if pif ();

   seg14_frame_driver #(
      .PWM_BITS  (4),
      .BLINK_BITS(2),
      .ACTIVE_LOW(1'b1)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .pat       (pif),
      .brightness(brightness),
      .blink_en  (blink_en),
      .lamp_test (lamp_test),
      .disp      (disp),
      .frame_tick(frame_tick)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] got,
                      input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, got, want,
                  $time);
      end
   endtask

   // Reference model: time is counted in cycles since reset release.
   // Phase within a frame is k mod 16, frame number is k div 16.
   exp_t        sb[$];
   int          m_k;
   logic [13:0] m_pend;
   bit          m_pfull;
   logic [13:0] m_act;
   int          m_br;

   always @(posedge clk) begin
      int   ph;
      int   fr;
      bit   lit;
      bit   acc;
      bit   swp;
      logic [13:0] seg;
      exp_t e;
      if (!rst_n) begin
         m_k = 0;
         m_pend = '0;
         m_pfull = 0;
         m_act = '0;
         m_br = 0;
      end else begin
         ph = m_k % FRAME;
         fr = m_k / FRAME;
         lit = (ph < m_br) && !(blink_en && ((fr % BLINK_FRAMES) >= 2));
         if (lamp_test) seg = 14'h3FFF;
         else if (lit) seg = m_act;
         else seg = 14'h0000;
         e.disp = ~seg;
         e.tick = (ph == FRAME - 1);
         acc = pif.pat_valid && !m_pfull;
         swp = (ph == FRAME - 1) && m_pfull;
         if (ph == FRAME - 1) m_br = int'(brightness);
         if (swp) begin
            m_act = m_pend;
            m_pfull = 0;
         end
         if (acc) begin
            m_pend = pif.pat_in;
            m_pfull = 1;
         end
         e.ready = !m_pfull;
         m_k++;
         sb.push_back(e);
      end
   end

   always @(posedge clk) begin
      exp_t e;
      #1;
      if (sb.size() > 0) begin
         e = sb.pop_front();
         chk("disp", 32'(disp), 32'(e.disp));
         chk("pat_ready", 32'(pif.pat_ready), 32'(e.ready));
         chk("frame_tick", 32'(frame_tick), 32'(e.tick));
      end
   end

   task automatic send(input logic [13:0] p);
      int n = 0;
      pif.pat_in = p;
      pif.pat_valid = 1'b1;
      while (!pif.pat_ready && n < 64) begin
         @(negedge clk);
         n++;
      end
      if (n >= 64) begin
         checks++;
         errors++;
         $display("FAIL send_timeout: pattern %h not accepted", p);
      end
      @(negedge clk);
      pif.pat_valid = 1'b0;
   endtask

   task automatic wait_tick();
      int n = 0;
      @(negedge clk);
      while (!frame_tick && n < 40) begin
         @(negedge clk);
         n++;
      end
      if (n >= 40) begin
         checks++;
         errors++;
         $display("FAIL tick_timeout: no frame_tick within 40 cycles");
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      int n;
      rst_n = 1'b0;
      pif.pat_in = '0;
      pif.pat_valid = 1'b0;
      brightness = 4'd0;
      blink_en = 1'b0;
      lamp_test = 1'b0;
      idle(3);
      rst_n = 1'b1;
      idle(5);

      brightness = 4'd8;
      send(14'h0A55);
      idle(3 * FRAME);

      brightness = 4'd12;
      send(14'h0001);
      send(14'h0002);
      idle(3 * FRAME);

      // Offer on the boundary cycle with an empty buffer.
      wait_tick();
      idle(FRAME - 1);
      send(14'h1234);
      idle(3 * FRAME);

      brightness = 4'd0;
      idle(2 * FRAME);
      brightness = 4'd15;
      idle(2 * FRAME);
      wait_tick();
      idle(6);
      brightness = 4'd3;
      idle(2 * FRAME);

      brightness = 4'd15;
      blink_en = 1'b1;
      idle(8 * FRAME);
      blink_en = 1'b0;
      idle(2 * FRAME);

      brightness = 4'd0;
      blink_en = 1'b1;
      idle(2 * FRAME);
      lamp_test = 1'b1;
      idle(10);
      lamp_test = 1'b0;
      idle(FRAME);
      blink_en = 1'b0;

      for (int i = 0; i < 30; i++) begin
         brightness = 4'($urandom_range(0, 15));
         blink_en = 1'($urandom_range(0, 1));
         lamp_test = ($urandom_range(0, 7) == 0);
         send(14'($urandom));
         idle($urandom_range(0, 24));
      end
      lamp_test = 1'b0;
      blink_en = 1'b0;

      // Asynchronous reset mid-frame with a pattern pending.
      brightness = 4'd10;
      wait_tick();
      send(14'h2AAA);
      #3;
      rst_n = 1'b0;
      #1;
      chk("rst_disp", 32'(disp), 32'h3FFF);
      chk("rst_ready", 32'(pif.pat_ready), 32'd1);
      chk("rst_tick", 32'(frame_tick), 32'd0);
      idle(3);
      rst_n = 1'b1;
      n = 0;
      while (n < 40) begin
         @(posedge clk);
         #1;
         n++;
         if (frame_tick) break;
      end
      chk("first_tick_cycles", 32'(n), 32'd16);
      send(14'h0F0F);
      idle(3 * FRAME);

      $display("Simulation finished: %0d checks, %0d errors", checks,
               errors);
      $finish;
   end

endmodule
